// File: rtl/div_root_arbiter.sv
// div_root_arbiter: round-robin arbiter that shares one divide / n-th root core
// between two requesters (A, B), issues a one-cycle start pulse, waits for
// the result under a timeout and returns a tagged response.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   a_valid/a_ready/a_mode/a_data_1/a_data_2   requester A (ready is combinational)
//   b_valid/b_ready/b_mode/b_data_1/b_data_2   requester B (ready is combinational)
//   core_in_valid/mode/data_1/data_2           start pulse + latched operands
//   core_out_valid/core_out_data               core result (10.10 fixed point)
//   rsp_valid/rsp_id/rsp_data/rsp_err          one-cycle tagged response
//   busy                                       high whenever not idle
module div_root_arbiter #(
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned CNT_W   = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic        a_mode,
   input  logic [9:0]  a_data_1,
   input  logic [2:0]  a_data_2,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic        b_mode,
   input  logic [9:0]  b_data_1,
   input  logic [2:0]  b_data_2,
   output logic        core_in_valid,
   output logic        core_in_mode,
   output logic [9:0]  core_in_data_1,
   output logic [2:0]  core_in_data_2,
   input  logic        core_out_valid,
   input  logic [19:0] core_out_data,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [19:0] rsp_data,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned D1_W  = 10;
   localparam int unsigned D2_W  = 3;
   localparam int unsigned RES_W = 20;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t            state, state_nxt;
   logic              last_grant;
   logic              id_q;
   logic [CNT_W-1:0]  cnt;
   logic              timeout_hit;

   logic              a_win, b_win, accept, acc_id, acc_mode;
   logic [D1_W-1:0]   acc_d1;
   logic [D2_W-1:0]   acc_d2;

   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = (acc_d2 == '0) ? S_RESP : S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (core_out_valid || timeout_hit) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Grant / ready decode; on a tie the requester not granted last time wins
   always_comb begin
      a_win    = a_valid && (!b_valid || last_grant);
      b_win    = b_valid && !a_win;
      a_ready  = (state == S_IDLE) && a_win;
      b_ready  = (state == S_IDLE) && b_win;
      accept   = a_ready || b_ready;
      acc_id   = b_ready;
      acc_mode = b_ready ? b_mode   : a_mode;
      acc_d1   = b_ready ? b_data_1 : a_data_1;
      acc_d2   = b_ready ? b_data_2 : a_data_2;
   end

   // Operand latches, latency counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant     <= 1'b1;
         id_q           <= 1'b0;
         cnt            <= '0;
         core_in_valid  <= 1'b0;
         core_in_mode   <= 1'b0;
         core_in_data_1 <= '0;
         core_in_data_2 <= '0;
         rsp_valid      <= 1'b0;
         rsp_id         <= 1'b0;
         rsp_data       <= '0;
         rsp_err        <= 1'b0;
         busy           <= 1'b0;
      end else begin
         core_in_valid <= (state_nxt == S_ISSUE);
         rsp_valid     <= (state_nxt == S_RESP);
         busy          <= (state_nxt != S_IDLE);

         if (accept) begin
            last_grant     <= acc_id;
            id_q           <= acc_id;
            core_in_mode   <= acc_mode;
            core_in_data_1 <= acc_d1;
            core_in_data_2 <= acc_d2;
            // Zero divisor / root order: answer immediately, core untouched
            if (acc_d2 == '0) begin
               rsp_id   <= acc_id;
               rsp_data <= '0;
               rsp_err  <= 1'b1;
            end
         end

         if (state == S_ISSUE) cnt <= '0;

         if (state == S_WAIT) begin
            if (core_out_valid) begin
               rsp_id   <= id_q;
               rsp_data <= core_out_data;
               rsp_err  <= 1'b0;
            end else if (timeout_hit) begin
               rsp_id   <= id_q;
               rsp_data <= RES_W'(0);
               rsp_err  <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
